// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read port plus packed valid/ready output stream.
// master = packer side, slave = FIFO/downstream side.
// Macro PACKER_FLUSH_EN adds the flush request and out_cnt word count.
`timescale 1ns/1ps
interface fifo_rd_packer_if #(
   parameter int DWIDTH = 16,
   parameter int PACK   = 2
);
   logic                     fifo_empty;
   logic                     rd_en;
   logic [DWIDTH-1:0]        rd_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [PACK*DWIDTH-1:0]   out_data;
`ifdef PACKER_FLUSH_EN
   logic                     flush;
   logic [$clog2(PACK+1)-1:0] out_cnt;

   modport master (
      input  fifo_empty, rd_data, out_ready, flush,
      output rd_en, out_valid, out_data, out_cnt
   );
   modport slave (
      output fifo_empty, rd_data, out_ready, flush,
      input  rd_en, out_valid, out_data, out_cnt
   );
`else
   modport master (
      input  fifo_empty, rd_data, out_ready,
      output rd_en, out_valid, out_data
   );
   modport slave (
      output fifo_empty, rd_data, out_ready,
      input  rd_en, out_valid, out_data
   );
`endif
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops DWIDTH-bit words from a 1-cycle-latency synchronous
// FIFO and packs PACK consecutive words into one output word, first-popped
// word in the least significant slot, delivered on a valid/ready stream.
// Optional macro PACKER_FLUSH_EN: flush input emits a partial word (unused
// upper slots zero) and out_cnt reports the number of valid words.
`timescale 1ns/1ps
module fifo_rd_packer #(
   parameter int DWIDTH = 16,
   parameter int PACK   = 2
) (
   input  logic             clk,
   input  logic             rstn,
   fifo_rd_packer_if.master bus
);
   localparam int CW = $clog2(PACK + 1);
   localparam logic [CW-1:0] W_PACK = CW'(PACK);

   logic [CW-1:0]          r_cnt;       // words captured into r_acc
   logic                   r_pend;      // read issued last cycle, data arrives now
   logic [PACK*DWIDTH-1:0] r_acc;
   logic [PACK*DWIDTH-1:0] r_out_data;
   logic                   r_out_valid;

   logic [CW-1:0]          w_cnt_next;
   logic [PACK*DWIDTH-1:0] w_acc_next;
   logic                   w_free;
   logic                   w_flush;
   logic                   w_full_go;
   logic                   w_flush_go;
   logic                   w_rd_en;

`ifdef PACKER_FLUSH_EN
   logic [CW-1:0]          r_out_cnt;
   assign w_flush = bus.flush;
`else
   assign w_flush = 1'b0;
`endif

   // Never request more than PACK outstanding words; no pops while flushing.
   assign w_rd_en    = rstn && !bus.fifo_empty && !w_flush &&
                       ((r_cnt + CW'(r_pend)) < W_PACK);
   assign w_cnt_next = r_cnt + CW'(r_pend);
   assign w_free     = !r_out_valid || bus.out_ready;
   assign w_full_go  = (w_cnt_next == W_PACK) && w_free;
   // A flush waits for an in-flight capture so that word is not lost.
   assign w_flush_go = w_flush && !r_pend && (r_cnt != '0) && w_free;

   // Drop the returning FIFO word into slot r_cnt of the assembly register.
   always_comb begin
      w_acc_next = r_acc;
      for (int i = 0; i < PACK; i++) begin
         if (r_pend && (r_cnt == CW'(i))) begin
            w_acc_next[i*DWIDTH +: DWIDTH] = bus.rd_data;
         end
      end
   end

   // Capture, completion/flush transfer into the output register, handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt       <= '0;
         r_pend      <= 1'b0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_pend <= w_rd_en;
         if (w_full_go) begin
            r_out_data  <= w_acc_next;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_acc       <= '0;
         end else if (w_flush_go) begin
            r_out_data  <= r_acc;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_acc       <= '0;
         end else begin
            // A full word waiting on a busy output simply holds at cnt==PACK.
            r_cnt <= w_cnt_next;
            r_acc <= w_acc_next;
            if (bus.out_ready) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

`ifdef PACKER_FLUSH_EN
   // Word count travelling with each loaded output word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out_cnt <= '0;
      end else if (w_full_go) begin
         r_out_cnt <= W_PACK;
      end else if (w_flush_go) begin
         r_out_cnt <= r_cnt;
      end
   end
   assign bus.out_cnt = r_out_cnt;
`endif

   assign bus.rd_en     = w_rd_en;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed scenarios on a PACK=2 packer and a randomized
// 10k-word run on a PACK=3 packer, both fed by queue-based FIFO models.
// Expected packed words are queued at stimulus time; a single monitor
// process pops and compares on every accepted output word.
`timescale 1ns/1ps
module tb_fifo_rd_packer;
   localparam int DW     = 16;
   localparam int PA     = 2;
   localparam int PB     = 3;
   localparam int NWORDS = 10002;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   fifo_rd_packer_if #(.DWIDTH(DW), .PACK(PA)) a_if ();
   fifo_rd_packer_if #(.DWIDTH(DW), .PACK(PB)) b_if ();

   fifo_rd_packer #(.DWIDTH(DW), .PACK(PA)) u_dut_a (
      .clk (clk),
      .rstn(rstn),
      .bus (a_if.master)
   );
   fifo_rd_packer #(.DWIDTH(DW), .PACK(PB)) u_dut_b (
      .clk (clk),
      .rstn(rstn),
      .bus (b_if.master)
   );

   typedef struct {
      string       name;
      logic [63:0] act;
      logic [63:0] exp;
   } req_t;

   req_t        req_q[$];
   logic [63:0] ea_q[$];
   logic [63:0] eb_q[$];
   int unsigned eca_q[$];
   logic [15:0] fa_q[$];
   logic [15:0] fb_q[$];

   int ra_cnt = 0;   // cycles with rd_en high on A
   int va_cnt = 0;   // cycles with out_valid high on A
   int acc_a  = 0;   // accepted words on A
   int acc_b  = 0;   // accepted words on B

   function automatic void tally(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
   endfunction

   task automatic req(string nm, logic [63:0] act, logic [63:0] exp);
      req_t r;
      r.name = nm;
      r.act  = act;
      r.exp  = exp;
      req_q.push_back(r);
   endtask

   task automatic exp_a(logic [63:0] d, int unsigned c);
      ea_q.push_back(d);
      eca_q.push_back(c);
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // FIFO models: pop on sampled rd_en, data valid the following cycle.
   initial begin
      a_if.fifo_empty = 1'b1;
      a_if.rd_data    = '0;
      b_if.fifo_empty = 1'b1;
      b_if.rd_data    = '0;
      forever begin
         @(posedge clk);
         if (a_if.rd_en && fa_q.size() > 0) a_if.rd_data <= fa_q.pop_front();
         if (b_if.rd_en && fb_q.size() > 0) b_if.rd_data <= fb_q.pop_front();
         a_if.fifo_empty <= (fa_q.size() == 0);
         b_if.fifo_empty <= (fb_q.size() == 0);
      end
   end

   // Monitor: the only process that scores comparisons.
   initial begin
      logic        pa_v, pa_r, pb_v, pb_r;
      logic [63:0] pa_d, pb_d;
      req_t        r;
      pa_v = 1'b0; pa_r = 1'b0; pa_d = '0;
      pb_v = 1'b0; pb_r = 1'b0; pb_d = '0;
      forever begin
         @(negedge clk);
         while (req_q.size() > 0) begin
            r = req_q.pop_front();
            tally(r.name, r.act, r.exp);
         end
         if (rstn) begin
            if (a_if.rd_en) begin
               ra_cnt++;
               tally("a_rd_while_empty", 64'(a_if.fifo_empty), 64'd0);
            end
            if (b_if.rd_en) tally("b_rd_while_empty", 64'(b_if.fifo_empty), 64'd0);
            if (a_if.out_valid) va_cnt++;
            if (pa_v && !pa_r) begin
               tally("a_hold_valid", 64'(a_if.out_valid), 64'd1);
               tally("a_hold_data", 64'(a_if.out_data), pa_d);
            end
            if (pb_v && !pb_r) begin
               tally("b_hold_valid", 64'(b_if.out_valid), 64'd1);
               tally("b_hold_data", 64'(b_if.out_data), pb_d);
            end
            if (a_if.out_valid && a_if.out_ready) begin
               acc_a++;
               if (ea_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL a_extra_word: got %0h, required no word", a_if.out_data);
               end else begin
                  tally("a_data", 64'(a_if.out_data), ea_q.pop_front());
`ifdef PACKER_FLUSH_EN
                  tally("a_out_cnt", 64'(a_if.out_cnt), 64'(eca_q.pop_front()));
`endif
               end
            end
            if (b_if.out_valid && b_if.out_ready) begin
               acc_b++;
               if (eb_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL b_extra_word: got %0h, required no word", b_if.out_data);
               end else begin
                  tally("b_data", 64'(b_if.out_data), eb_q.pop_front());
`ifdef PACKER_FLUSH_EN
                  tally("b_out_cnt", 64'(b_if.out_cnt), 64'(PB));
`endif
               end
            end
            pa_v = a_if.out_valid; pa_r = a_if.out_ready; pa_d = 64'(a_if.out_data);
            pb_v = b_if.out_valid; pb_r = b_if.out_ready; pb_d = 64'(b_if.out_data);
         end else begin
            pa_v = 1'b0;
            pb_v = 1'b0;
         end
      end
   end

   // Hard stop if anything wedges.
   initial begin
      #3ms;
      $display("FAIL global_timeout: got running, required finished");
      $fatal(1, "timeout");
   end

   // Stimulus.
   initial begin
      int          s_rd, s_v, s_acc, t0, lat, pushed;
      logic [15:0] w;
      logic [15:0] grp[$];

      a_if.out_ready = 1'b0;
      b_if.out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
      a_if.flush = 1'b0;
      b_if.flush = 1'b0;
`endif
      rstn = 1'b0;
      step(3);
      req("rst_a_rd_en", 64'(a_if.rd_en), 64'd0);
      req("rst_a_valid", 64'(a_if.out_valid), 64'd0);
      req("rst_a_data", 64'(a_if.out_data), 64'd0);
      req("rst_b_valid", 64'(b_if.out_valid), 64'd0);
      req("rst_b_data", 64'(b_if.out_data), 64'd0);
      rstn = 1'b1;
      step(2);

      // Two words, downstream ready: one packed word, LSB slot first.
      a_if.out_ready = 1'b1;
      s_rd  = ra_cnt;
      s_acc = acc_a;
      exp_a(64'h2222_1111, PA);
      fa_q.push_back(16'h1111);
      fa_q.push_back(16'h2222);
      t0  = -1;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_if.rd_en && t0 < 0) t0 = i;
         if (a_if.out_valid && t0 >= 0) begin
            lat = i - t0;
            break;
         end
      end
      // rd_en is sampled one edge later; the word is registered PACK edges after that.
      req("t1_latency", 64'(lat), 64'(PA + 1));
      step(10);
      req("t1_rd_cycles", 64'(ra_cnt - s_rd), 64'd2);
      req("t1_words", 64'(acc_a - s_acc), 64'd1);

      // Empty FIFO: no pops, no output.
      s_rd = ra_cnt;
      s_v  = va_cnt;
      step(100);
      req("t2_rd_cycles", 64'(ra_cnt - s_rd), 64'd0);
      req("t2_valid_cycles", 64'(va_cnt - s_v), 64'd0);

      // Backpressure: first word held, second pair captured, then pops stop.
      a_if.out_ready = 1'b0;
      s_rd  = ra_cnt;
      s_acc = acc_a;
      exp_a(64'h0002_0001, PA);
      exp_a(64'h0004_0003, PA);
      exp_a(64'h0006_0005, PA);
      for (int i = 1; i <= 6; i++) fa_q.push_back(16'(i));
      step(20);
      req("t3_rd_cycles", 64'(ra_cnt - s_rd), 64'd4);
      req("t3_fifo_left", 64'(fa_q.size()), 64'd2);
      req("t3_hold_valid", 64'(a_if.out_valid), 64'd1);
      req("t3_hold_data", 64'(a_if.out_data), 64'h0002_0001);
      a_if.out_ready = 1'b1;
      step(20);
      req("t3_words", 64'(acc_a - s_acc), 64'd3);
      req("t3_drained", 64'(ea_q.size()), 64'd0);

      // Single word then empty: partial held, nothing emitted.
      s_rd = ra_cnt;
      s_v  = va_cnt;
      fa_q.push_back(16'hABCD);
      step(20);
      req("t4_rd_cycles", 64'(ra_cnt - s_rd), 64'd1);
      req("t4_valid_cycles", 64'(va_cnt - s_v), 64'd0);
`ifdef PACKER_FLUSH_EN
      exp_a(64'h0000_ABCD, 1);
      a_if.flush = 1'b1;
      step(1);
      a_if.flush = 1'b0;
      step(10);
      req("t4_flush_drained", 64'(ea_q.size()), 64'd0);
`endif

      // Reset with a read in flight: returned word must be discarded.
      fa_q.push_back(16'h7777);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_if.rd_en) break;
      end
      @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      req("t5_rst_rd_en", 64'(a_if.rd_en), 64'd0);
      req("t5_rst_valid", 64'(a_if.out_valid), 64'd0);
      req("t5_rst_data", 64'(a_if.out_data), 64'd0);
      step(2);
      rstn = 1'b1;
      step(1);
      s_acc = acc_a;
      exp_a(64'h4444_3333, PA);
      fa_q.push_back(16'h3333);
      fa_q.push_back(16'h4444);
      step(20);
      req("t5_words", 64'(acc_a - s_acc), 64'd1);
      req("t5_drained", 64'(ea_q.size()), 64'd0);

      // Randomized run on the PACK=3 packer.
      pushed = 0;
      while (pushed < NWORDS) begin
         if ($urandom_range(0, 1) == 1) begin
            w = 16'($urandom);
            fb_q.push_back(w);
            grp.push_back(w);
            pushed++;
            if (grp.size() == PB) begin
               eb_q.push_back(64'({grp[2], grp[1], grp[0]}));
               grp.delete();
            end
         end
         b_if.out_ready = ($urandom_range(0, 9) < 7);
         step(1);
      end
      b_if.out_ready = 1'b1;
      for (int i = 0; i < 2000 && eb_q.size() > 0; i++) step(1);
      req("b_drained", 64'(eb_q.size()), 64'd0);
      req("b_words", 64'(acc_b), 64'(NWORDS / PB));

      step(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
